serial_slt: RTL and testbench
=============================

// Module: serial_slt
// PURPOSE
//   Bit-serial signed less-than/equal comparator. It receives two N-bit two's-complement
//   operands LSB-first on single-bit lines and computes I0-I1 with one full adder and a
//   carry flop. It emits LT/EQ flags once per operand pair, for serial links that cannot
//   afford an N-bit parallel SLT.
// PARAMETERS
//   N      4    operand width in bits (>=2); also the number of shift cycles per compare
// PORTS
//   CLK     in   1         rising-edge clock; the only clock
//   RESETN  in   1         synchronous, active-low reset
//   START   in   1         begin a compare; bit 0 of both operands is valid in this same cycle
//   I0      in   1         serial operand A, LSB first
//   I1      in   1         serial operand B, LSB first
//   BUSY    out  1         high while bits 1..N-1 are being accepted
//   VALID   out  1         one-cycle pulse: LT/EQ valid
//   LT      out  1         signed A < B; held until the next accepted START
//   EQ      out  1         A == B; held until the next accepted START
// BEHAVIOUR
//   - Reset (RESETN=0 at a CLK edge): state=IDLE; carry=1, cnt=0, zacc=1;
//     BUSY=0, VALID=0, LT=0, EQ=0. Reset overrides all other inputs.
//     Reset during SHIFT abandons the compare and produces no VALID.
//   - FSM states:
//     IDLE  --START-->  SHIFT
//     SHIFT --cnt==N-1-->  DONE
//     DONE  --START-->  SHIFT
//     DONE  --!START-->  IDLE
//   - Acceptance rules:
//     * START is accepted only in IDLE or DONE. In those states the cycle START is high
//       consumes bit 0: d = I0 ^ ~I1 ^ 1, carry <= maj(I0, ~I1, 1), zacc <= (d==0), cnt <= 1.
//     * START in SHIFT is ignored and does not restart the compare.
//   - SHIFT: each cycle consumes bit cnt with d = I0 ^ ~I1 ^ carry.
//     * carry <= maj(I0, ~I1, carry); zacc <= zacc & ~d; cnt <= cnt+1.
//     * On bit N-1 (MSB), with a=I0, b=I1, d the difference MSB:
//       LT <= (a & ~b) | (~(a^b) & d); EQ <= zacc & ~d; then enter DONE.
//     * This LT formula corrects for overflow; it is exact over the full signed range.
//   - DONE lasts exactly one cycle. VALID=1 only in DONE.
//   - Latency: START at cycle t, last bit at t+N-1, VALID at t+N.
//     Throughput is one compare per N cycles: START in the DONE cycle begins the next
//     compare back-to-back, and VALID and the new bit 0 coexist.
//   - BUSY=1 exactly in SHIFT. LT/EQ change only on the MSB cycle or at reset.
//   - I0/I1 are don't-care outside accepted bit cycles.
//   - cnt width is $clog2(N)+1; it never wraps within a compare.
// STRUCTURE
//   - Shared package serial_pkg: state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and
//     function maj3. The same package is reused by the future serial adder/subtractor.
//   - One sub-module, serial_full_adder: 1-bit sum/carry, combinational, one LUT + one
//     SB_CARRY on ice40. All flops (carry, cnt, zacc, LT, EQ, state) stay in serial_slt.
// TESTING (N=4; operands are shifted LSB-first starting in the START cycle)
//   1. A=3, B=5: START at t -> VALID at t+4 with LT=1, EQ=0; BUSY high t+1..t+3.
//   2. A=-8, B=7 (overflow case) -> LT=1, EQ=0. A=7, B=-8 -> LT=0, EQ=0.
//   3. A=-1, B=-1 -> LT=0, EQ=1. A=0, B=0 -> LT=0, EQ=1.
//   4. Back-to-back: (2,1) then START in the DONE cycle with (-2,1)
//      -> VALID at t+4 LT=0, VALID at t+8 LT=1; no idle cycle between compares.
//   5. START pulsed at t+2 during a compare -> ignored; result is unchanged and VALID
//      occurs only at t+4.
//   6. RESETN=0 at t+2 mid-compare -> next cycle BUSY=0, VALID=0, LT=0, EQ=0;
//      no VALID at t+4; a new START after release completes normally.
//   7. Exhaustive random: all 256 (A,B) pairs against a signed reference model.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding and majority helper.
package serial_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } serial_state_e;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/serial_full_adder.sv
// One-bit full adder, purely combinational (zero latency, no flow control).
module serial_full_adder
   import serial_pkg::*;
(
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);

   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = maj3(a_i, b_i, c_i);

endmodule

// File: rtl/serial_slt.sv
// Bit-serial signed compare: computes I0-I1 LSB-first and reports LT/EQ one cycle after the MSB.
// Latency N cycles from START to VALID; START is ignored while BUSY, no other backpressure.
module serial_slt
   import serial_pkg::*;
#(
   parameter int N = 4
) (
   input  logic CLK,
   input  logic RESETN,
   input  logic START,
   input  logic I0,
   input  logic I1,
   output logic BUSY,
   output logic VALID,
   output logic LT,
   output logic EQ
);

   localparam int CW = $clog2(N) + 1;

   serial_state_e   state_q, state_d;
   logic            carry_q, carry_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            zacc_q, zacc_d;
   logic            lt_q, lt_d;
   logic            eq_q, eq_d;

   logic            fa_cin;
   logic            diff;
   logic            fa_cout;
   logic            last_bit;

   // Subtraction as I0 + ~I1 + 1: the +1 enters as carry-in on bit 0.
   assign fa_cin   = (state_q == ST_SHIFT) ? carry_q : 1'b1;
   assign last_bit = (cnt_q == CW'(N - 1));

   serial_full_adder u_fa (
      .a_i (I0),
      .b_i (~I1),
      .c_i (fa_cin),
      .s_o (diff),
      .c_o (fa_cout)
   );

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state_q <= ST_IDLE;
         carry_q <= 1'b1;
         cnt_q   <= '0;
         zacc_q  <= 1'b1;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         zacc_q  <= zacc_d;
         lt_q    <= lt_d;
         eq_q    <= eq_d;
      end
   end

   always_comb begin
      state_d = state_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      zacc_d  = zacc_q;
      lt_d    = lt_q;
      eq_d    = eq_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (START) begin
               state_d = ST_SHIFT;
               carry_d = fa_cout;
               zacc_d  = ~diff;
               cnt_d   = CW'(1);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            carry_d = fa_cout;
            zacc_d  = zacc_q & ~diff;
            cnt_d   = cnt_q + CW'(1);
            if (last_bit) begin
               // Sign-aware: differing signs decide directly, otherwise no overflow and diff MSB is the sign.
               lt_d    = (I0 & ~I1) | (~(I0 ^ I1) & diff);
               eq_d    = zacc_q & ~diff;
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign BUSY  = (state_q == ST_SHIFT);
   assign VALID = (state_q == ST_DONE);
   assign LT    = lt_q;
   assign EQ    = eq_q;

endmodule

// File: tb/tb_serial_slt.sv
// Directed and exhaustive self-checking bench for serial_slt with N=4.
module tb_serial_slt;

   logic CLK = 1'b0;
   logic RESETN, START, I0, I1;
   logic BUSY, VALID, LT, EQ;

   int n_checks = 0;
   int n_errors = 0;

   serial_slt #(.N(4)) dut (
      .CLK    (CLK),
      .RESETN (RESETN),
      .START  (START),
      .I0     (I0),
      .I1     (I1),
      .BUSY   (BUSY),
      .VALID  (VALID),
      .LT     (LT),
      .EQ     (EQ)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Called at a negedge; drives bit 0 with START, shifts the rest, and checks the
   // result at the negedge where VALID should be up. Leaves START low on return so a
   // caller may immediately start the next compare back-to-back.
   task automatic run_cmp(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic exp_lt, input logic exp_eq, input int poke_start_at);
      START = 1'b1;
      I0    = a[0];
      I1    = b[0];
      for (int i = 1; i < 4; i++) begin
         @(negedge CLK);
         check({tag, " busy"},  BUSY,  1);
         check({tag, " valid"}, VALID, 0);
         START = (i == poke_start_at);
         I0    = a[i];
         I1    = b[i];
      end
      @(negedge CLK);
      START = 1'b0;
      check({tag, " valid@4"}, VALID, 1);
      check({tag, " busy@4"},  BUSY,  0);
      check({tag, " lt"},      LT,    exp_lt);
      check({tag, " eq"},      EQ,    exp_eq);
   endtask

   initial begin
      logic [3:0] a, b;
      logic       elt, eeq;

      RESETN = 1'b0;
      START  = 1'b0;
      I0     = 1'b0;
      I1     = 1'b0;
      repeat (2) @(negedge CLK);
      check("reset busy",  BUSY,  0);
      check("reset valid", VALID, 0);
      check("reset lt",    LT,    0);
      check("reset eq",    EQ,    0);
      RESETN = 1'b1;
      @(negedge CLK);
      check("idle valid", VALID, 0);

      // 1. 3 < 5; flags hold after the VALID pulse
      run_cmp("t1 3<5", 4'd3, 4'd5, 1'b1, 1'b0, 0);
      @(negedge CLK);
      check("t1 valid pulse", VALID, 0);
      check("t1 lt held",     LT,    1);
      check("t1 eq held",     EQ,    0);

      // 2. overflow corners
      run_cmp("t2 -8<7", 4'b1000, 4'b0111, 1'b1, 1'b0, 0);
      @(negedge CLK);
      run_cmp("t2 7<-8", 4'b0111, 4'b1000, 1'b0, 1'b0, 0);
      @(negedge CLK);

      // 3. equality
      run_cmp("t3 -1==-1", 4'b1111, 4'b1111, 1'b0, 1'b1, 0);
      @(negedge CLK);
      run_cmp("t3 0==0", 4'd0, 4'd0, 1'b0, 1'b1, 0);
      @(negedge CLK);

      // 4. back-to-back: START in the DONE cycle
      run_cmp("t4 2<1", 4'd2, 4'd1, 1'b0, 1'b0, 0);
      run_cmp("t4 -2<1", 4'b1110, 4'd1, 1'b1, 1'b0, 0);
      @(negedge CLK);
      check("t4 idle after", VALID, 0);

      // 5. START mid-compare ignored
      run_cmp("t5 poke", 4'd3, 4'd5, 1'b1, 1'b0, 2);
      @(negedge CLK);
      check("t5 no extra valid", VALID, 0);
      check("t5 no extra busy",  BUSY,  0);

      // 6. reset mid-compare (LT=1 from previous compare must clear)
      START = 1'b1; I0 = 1'b1; I1 = 1'b0;
      @(negedge CLK);
      START = 1'b0; I0 = 1'b1; I1 = 1'b0;
      @(negedge CLK);
      RESETN = 1'b0;
      @(negedge CLK);
      check("t6 busy",  BUSY,  0);
      check("t6 valid", VALID, 0);
      check("t6 lt",    LT,    0);
      check("t6 eq",    EQ,    0);
      RESETN = 1'b1;
      @(negedge CLK);
      check("t6 no valid@4", VALID, 0);
      run_cmp("t6 after", 4'b1001, 4'd2, 1'b1, 1'b0, 0);
      @(negedge CLK);

      // 7. exhaustive, back-to-back
      for (int i = 0; i < 256; i++) begin
         a   = 4'(i >> 4);
         b   = 4'(i);
         elt = ($signed(a) < $signed(b));
         eeq = (a == b);
         run_cmp($sformatf("t7 a=%0d b=%0d", $signed(a), $signed(b)), a, b, elt, eeq, 0);
      end
      @(negedge CLK);
      check("t7 end idle", VALID, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
